vram_port_arbiter: RTL

- Memory-side consumer for the CPU write queue (memStoreQueue).
- Owns the single port of the vector RAM BRAM and time-shares it between two users: drained CPU writes (grant = can_write) and vector-generator reads.
- Sits between the write queue, the vector generator and the BRAM_VECTOR block.
- Guarantees forward progress for queued writes with a starvation limit.

---
 rtl/vram_arb_pkg.sv | 19 +
 rtl/valid_delay_line.sv | 36 +++
 rtl/vram_port_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the vector-RAM port arbiter.
package vram_arb_pkg;

    // Owner of the BRAM port for the current cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WSLOT = 2'd1,
        RSLOT = 2'd2
    } slot_t;

    localparam logic [15:0] VRAM_BASE_DEFAULT = 16'h2000;
    localparam int          VRAM_AW_DEFAULT   = 13;

    // True when a window-relative offset addresses a word inside the RAM.
    function automatic logic in_window(input logic [15:0] off, input int aw);
        return (off >> aw) == 16'd0;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register carrying read-valid tokens alongside a
// pipelined memory read. A flush kills every token in flight, including the
// one that would emerge during the flush cycle itself.
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_one
            // Single-stage token register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        sr <= '0;
                else if (flush) sr <= '0;
                else            sr <= din;
            end
        end else begin : g_many
            // Multi-stage token shift register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        sr <= '0;
                else if (flush) sr <= '0;
                else            sr <= {sr[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = sr[DEPTH-1] & ~flush;

endmodule

// File: rtl/vram_port_arbiter.sv
// Time-shares the single vector-RAM BRAM port between drained CPU writes
// and vector-generator reads, with a starvation limit for pending writes.
//
//   slot  | meaning
//   IDLE  | port unused (after reset or vector-generator reset)
//   WSLOT | write queue granted (can_write=1); a presented write commits
//   RSLOT | vector generator owns the port; a request is acked and issued
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter logic [15:0] VRAM_BASE    = VRAM_BASE_DEFAULT,
    parameter int          VRAM_AW      = VRAM_AW_DEFAULT,
    parameter int          READ_LATENCY = 1,
    parameter int          MAX_STARVE   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_pending,
    output logic               can_write,
    input  logic               wr_valid,
    input  logic [15:0]        wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               vg_req,
    input  logic [VRAM_AW-1:0] vg_addr,
    output logic               vg_ack,
    output logic [7:0]         vg_data,
    output logic               vg_data_valid,
    input  logic               vgrst,
    output logic [VRAM_AW-1:0] bram_addr,
    output logic [7:0]         bram_din,
    output logic               bram_we,
    input  logic [7:0]         bram_dout,
    output logic               wr_drop
);

    localparam int SW = (MAX_STARVE < 2) ? 1 : $clog2(MAX_STARVE + 1);

    slot_t         slot;
    slot_t         slot_nxt;
    logic [SW-1:0] starve_cnt;
    logic          starve_max;
    logic [15:0]   off;
    logic          win;
    logic          commit;
    logic          rd_issue;

    assign off        = wr_addr - VRAM_BASE;
    assign win        = in_window(off, VRAM_AW);
    assign commit     = (slot == WSLOT) && wr_valid;
    assign starve_max = (starve_cnt == SW'(MAX_STARVE));

    // Next slot: vector-generator reset wins, then a starved write, then reads.
    always_comb begin
        slot_nxt = WSLOT;
        if (vgrst)                         slot_nxt = IDLE;
        else if (starve_max && wr_pending) slot_nxt = WSLOT;
        else if (vg_req)                   slot_nxt = RSLOT;
    end

    // Slot register; the grant is its own flop so it never sees wr_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= IDLE;
            can_write <= 1'b0;
        end else begin
            slot      <= slot_nxt;
            can_write <= (slot_nxt == WSLOT);
        end
    end

    // Port mux driven by the current slot owner.
    always_comb begin
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = wr_data;
        vg_ack    = 1'b0;
        rd_issue  = 1'b0;
        case (slot)
            WSLOT: begin
                if (wr_valid) begin
                    bram_addr = off[VRAM_AW-1:0];
                    bram_we   = win;
                end
            end
            RSLOT: begin
                bram_addr = vg_addr;
                vg_ack    = vg_req;
                rd_issue  = vg_req;
            end
            default: begin
                bram_we = 1'b0;
            end
        endcase
    end

    // Starvation counter: restarts whenever the write side is not waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (commit || !wr_pending || vgrst) begin
            starve_cnt <= '0;
        end else if (!starve_max) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Out-of-window writes are consumed silently but flagged one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_drop <= 1'b0;
        else     wr_drop <= commit && !win;
    end

    valid_delay_line #(
        .DEPTH (READ_LATENCY)
    ) u_rd_valid (
        .clk   (clk),
        .rst   (rst),
        .flush (vgrst),
        .din   (rd_issue),
        .dout  (vg_data_valid)
    );

    assign vg_data = bram_dout;

endmodule
